// File: rtl/mcb_burst_sched.sv
// rtl/mcb_burst_sched.sv - staging-BRAM <-> MCB p0 burst scheduler, write-priority
// Optional read-data watchdog built only when MCB_SCHED_TIMEOUT_EN is defined.
module mcb_burst_sched #(
    parameter int BURST_LEN   = 64,
    parameter int ADDR_W      = 23,
    parameter int BUF_AW      = 11,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              calib_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              timeout,
    output logic [BUF_AW-1:0] buf_addr,
    output logic              buf_en,
    output logic              buf_we,
    output logic [63:0]       buf_wdata,
    input  logic [63:0]       buf_rdata,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [29:0]       cmd_byte_addr,
    input  logic              cmd_full,
    output logic              wr_en,
    output logic [63:0]       wr_data,
    input  logic              wr_full,
    output logic              rd_en,
    input  logic [63:0]       rd_data,
    input  logic              rd_empty
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRD   = 3'd1,
        WPUSH = 3'd2,
        WCMD  = 3'd3,
        RCMD  = 3'd4,
        RPOP  = 3'd5,
        RST   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic                wr_pend_q, wr_pend_d;
    logic                rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   act_addr_q, act_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BUF_AW-1:0]   buf_addr_q, buf_addr_d;
    logic [63:0]         buf_wdata_q, buf_wdata_d;
    logic [63:0]         wdata_hold_q, wdata_hold_d;
    logic                wfirst_q, wfirst_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                wr_clr, rd_clr, wr_ovr, rd_ovr;

`ifdef MCB_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                timeout_q, timeout_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            act_addr_q   <= '0;
            cnt_q        <= '0;
            buf_addr_q   <= '0;
            buf_wdata_q  <= '0;
            wdata_hold_q <= '0;
            wfirst_q     <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef MCB_SCHED_TIMEOUT_EN
            wd_q         <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_pend_q    <= wr_pend_d;
            rd_pend_q    <= rd_pend_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            act_addr_q   <= act_addr_d;
            cnt_q        <= cnt_d;
            buf_addr_q   <= buf_addr_d;
            buf_wdata_q  <= buf_wdata_d;
            wdata_hold_q <= wdata_hold_d;
            wfirst_q     <= wfirst_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
`ifdef MCB_SCHED_TIMEOUT_EN
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        act_addr_d    = act_addr_q;
        cnt_d         = cnt_q;
        buf_addr_d    = buf_addr_q;
        buf_wdata_d   = buf_wdata_q;
        wfirst_d      = 1'b0;
        done_d        = 1'b0;
        wr_clr        = 1'b0;
        rd_clr        = 1'b0;
        buf_en        = 1'b0;
        buf_we        = 1'b0;
        cmd_en        = 1'b0;
        cmd_instr     = 3'b000;
        cmd_byte_addr = '0;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
`ifdef MCB_SCHED_TIMEOUT_EN
        wd_d          = '0;
        timeout_d     = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (calib_done) begin
                    if (wr_pend_q) begin
                        wr_clr     = 1'b1;
                        state_d    = WRD;
                        cnt_d      = '0;
                        buf_addr_d = wr_addr_q[BUF_AW-1:0];
                        act_addr_d = wr_addr_q;
                    end else if (rd_pend_q) begin
                        rd_clr     = 1'b1;
                        state_d    = RCMD;
                        act_addr_d = rd_addr_q;
                    end
                end
            end
            WRD: begin
                buf_en   = 1'b1;
                wfirst_d = 1'b1;
                state_d  = WPUSH;
            end
            WPUSH: begin
                if (!wr_full) begin
                    wr_en      = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    buf_addr_d = buf_addr_q + BUF_AW'(1);
                    state_d    = (cnt_q == CNT_LAST) ? WCMD : WRD;
                end
            end
            WCMD: begin
                cmd_byte_addr = 30'({act_addr_q, 3'b000});
                if (!cmd_full) begin
                    cmd_en  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RCMD: begin
                cmd_instr     = 3'b001;
                cmd_byte_addr = 30'({act_addr_q, 3'b000});
                if (!cmd_full) begin
                    cmd_en     = 1'b1;
                    cnt_d      = '0;
                    buf_addr_d = act_addr_q[BUF_AW-1:0];
                    state_d    = RPOP;
                end
            end
            RPOP: begin
                if (!rd_empty) begin
                    rd_en       = 1'b1;
                    buf_wdata_d = rd_data;
                    state_d     = RST;
                end
`ifdef MCB_SCHED_TIMEOUT_EN
                // abandon the burst; remaining words never reach the BRAM
                else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            RST: begin
                buf_en     = 1'b1;
                buf_we     = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                buf_addr_d = buf_addr_q + BUF_AW'(1);
                if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RPOP;
                end
            end
            default: state_d = IDLE;
        endcase

        // a request landing on the cycle its flag clears is a fresh request
        wr_ovr       = wr_req & wr_pend_q & ~wr_clr;
        rd_ovr       = rd_req & rd_pend_q & ~rd_clr;
        wr_pend_d    = (wr_pend_q & ~wr_clr) | wr_req;
        rd_pend_d    = (rd_pend_q & ~rd_clr) | rd_req;
        wr_addr_d    = (wr_req & ~wr_ovr) ? wr_addr : wr_addr_q;
        rd_addr_d    = (rd_req & ~rd_ovr) ? rd_addr : rd_addr_q;
        overrun_d    = overrun_q | wr_ovr | rd_ovr;
        wdata_hold_d = wfirst_q ? buf_rdata : wdata_hold_q;
    end

    // BRAM data is live only in the first WPUSH cycle; the hold copy covers wr_full stalls
    assign wr_data   = wfirst_q ? buf_rdata : wdata_hold_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdata = buf_wdata_q;
    assign cmd_bl    = 6'(BURST_LEN - 1);
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE) | wr_pend_q | rd_pend_q;

`ifdef MCB_SCHED_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mcb_burst_sched.sv
// tb/tb_mcb_burst_sched.sv - scoreboard bench for mcb_burst_sched
module tb_mcb_burst_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        calib_done = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0;
    logic [22:0] wr_addr = '0, rd_addr = '0;
    logic        busy, done, overrun, timeout;
    logic [10:0] buf_addr;
    logic        buf_en, buf_we;
    logic [63:0] buf_wdata;
    logic [63:0] buf_rdata = '0;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_full = 1'b0;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        wr_full = 1'b0;
    logic        rd_en;
    logic [63:0] rd_data = '0;
    logic        rd_empty = 1'b1;

    mcb_burst_sched dut (
        .clock(clock), .reset(reset), .calib_done(calib_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .rd_req(rd_req), .rd_addr(rd_addr),
        .busy(busy), .done(done), .overrun(overrun), .timeout(timeout),
        .buf_addr(buf_addr), .buf_en(buf_en), .buf_we(buf_we),
        .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
    );

    always #5 clock = ~clock;

    int n_tests = 0, n_fail = 0;
    int n_wr_en = 0, n_rd_en = 0, n_rd_acc = 0, n_popped = 0;
    int n_cmd = 0, n_bufw = 0, n_done = 0, n_strobe = 0;
    logic [63:0] exp_wr[$];
    logic [32:0] exp_cmd[$];
    logic [74:0] exp_bufw[$];
    logic [63:0] rfifo[$];
    logic [63:0] mem [0:2047];
    int          rd_supply = 64;
    logic [63:0] rd_base = '0;
    bit          gaps = 1'b0;
    bit          prev_wcmd = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // BRAM port B read model: data valid one cycle after buf_en
    always @(posedge clock) begin
        if (buf_en && !buf_we) buf_rdata <= mem[buf_addr];
    end

    // MCB read FIFO model, updated just after the clock edge
    always begin
        @(posedge clock);
        #1;
        while (n_popped < n_rd_acc) begin
            if (rfifo.size() > 0) void'(rfifo.pop_front());
            n_popped++;
        end
        rd_empty = (rfifo.size() == 0) || (gaps && $urandom_range(0, 2) == 0);
        rd_data  = (rfifo.size() > 0) ? rfifo[0] : 64'h0;
    end

    // output monitor and scoreboard comparisons
    always @(negedge clock) begin
        if (reset) begin
            prev_wcmd = 1'b0;
        end else begin
            if (prev_wcmd) check("done_after_wcmd", done, 1'b1);
            prev_wcmd = cmd_en && (cmd_instr == 3'b000);
            if (cmd_en | wr_en | rd_en | buf_en) n_strobe++;
            if (done) n_done++;
            if (wr_en) begin
                n_wr_en++;
                check("wr_en_while_full", wr_full, 1'b0);
                check("wr_expected", exp_wr.size() != 0, 1'b1);
                if (exp_wr.size() != 0) check("wr_data", wr_data, exp_wr.pop_front());
            end
            if (cmd_en) begin
                n_cmd++;
                check("cmd_en_while_full", cmd_full, 1'b0);
                check("cmd_bl", cmd_bl, 6'd63);
                check("cmd_expected", exp_cmd.size() != 0, 1'b1);
                if (exp_cmd.size() != 0) check("cmd", {cmd_instr, cmd_byte_addr}, exp_cmd.pop_front());
                if (cmd_instr == 3'b001)
                    for (int i = 0; i < rd_supply; i++) rfifo.push_back(rd_base + 64'(i));
            end
            if (rd_en) begin
                n_rd_en++;
                check("rd_en_while_empty", rd_empty, 1'b0);
                if (!rd_empty) n_rd_acc++;
            end
            if (buf_we) begin
                n_bufw++;
                check("bufw_expected", exp_bufw.size() != 0, 1'b1);
                if (exp_bufw.size() != 0) check("buf_write", {buf_addr, buf_wdata}, exp_bufw.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start = n_done;
        int i = 0;
        while (n_done == start && i < budget) begin
            tick();
            i++;
        end
        check(tag, n_done != start, 1'b1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_flags"}, {busy, done, overrun, timeout, buf_en, buf_we, cmd_en, wr_en, rd_en, cmd_instr}, '0);
        check({tag, "_buf_addr"}, buf_addr, '0);
        check({tag, "_buf_wdata"}, buf_wdata, '0);
        check({tag, "_wr_data"}, wr_data, '0);
        check({tag, "_cmd_addr"}, cmd_byte_addr, '0);
        check({tag, "_cmd_bl"}, cmd_bl, 6'd63);
    endtask

    task automatic load_wr_block(input int base, input logic [63:0] dbase);
        for (int i = 0; i < 64; i++) begin
            mem[base + i] = dbase + 64'(i);
            exp_wr.push_back(dbase + 64'(i));
        end
    endtask

    task automatic expect_rd_block(input int base, input logic [63:0] dbase, input int n);
        for (int i = 0; i < n; i++) exp_bufw.push_back({11'(base + i), dbase + 64'(i)});
    endtask

    initial begin
        int s_wr, s_rd, s_cmd, s_bw, s_st, k;
        for (int i = 0; i < 2048; i++) mem[i] = 64'hDEAD_0000 + 64'(i);

        // reset state
        repeat (3) tick();
        check_reset_outs("reset");
        reset = 1'b0;
        calib_done = 1'b1;
        tick();
        check("idle_busy", busy, 1'b0);

        // single write block
        load_wr_block('h40, 64'h0);
        exp_cmd.push_back({3'b000, 30'h200});
        s_wr = n_wr_en; s_rd = n_rd_en; s_cmd = n_cmd; s_bw = n_bufw;
        wr_addr = 23'h40; wr_req = 1'b1; tick(); wr_req = 1'b0;
        check("t1_busy", busy, 1'b1);
        wait_done(400, "t1_done");
        check("t1_wr_count", n_wr_en - s_wr, 64);
        check("t1_cmd_count", n_cmd - s_cmd, 1);
        check("t1_no_rd", (n_rd_en - s_rd) + (n_bufw - s_bw), 0);
        tick();
        check("t1_idle", busy, 1'b0);

        // single read block with random FIFO gaps
        rd_base = 64'hA0; gaps = 1'b1;
        expect_rd_block('h80, 64'hA0, 64);
        exp_cmd.push_back({3'b001, 30'h400});
        s_wr = n_wr_en; s_rd = n_rd_en; s_cmd = n_cmd; s_bw = n_bufw;
        rd_addr = 23'h80; rd_req = 1'b1; tick(); rd_req = 1'b0;
        wait_done(2000, "t2_done");
        gaps = 1'b0;
        check("t2_rd_count", n_rd_en - s_rd, 64);
        check("t2_bufw_count", n_bufw - s_bw, 64);
        check("t2_cmd_count", n_cmd - s_cmd, 1);
        check("t2_no_wr", n_wr_en - s_wr, 0);

        // priority, overrun and calibration gating
        calib_done = 1'b0;
        for (int i = 0; i < 64; i++) mem['h300 + i] = 64'h3000 + 64'(i);
        load_wr_block('h100, 64'h1000);
        rd_base = 64'h2000;
        expect_rd_block('h200, 64'h2000, 64);
        exp_cmd.push_back({3'b000, 30'h800});
        exp_cmd.push_back({3'b001, 30'h1000});
        s_wr = n_wr_en; s_st = n_strobe;
        wr_addr = 23'h100; rd_addr = 23'h200; wr_req = 1'b1; rd_req = 1'b1; tick();
        rd_req = 1'b0; wr_addr = 23'h300; tick();
        wr_req = 1'b0;
        repeat (10) tick();
        check("t3_busy_uncal", busy, 1'b1);
        check("t3_overrun", overrun, 1'b1);
        check("t3_no_strobes_uncal", n_strobe - s_st, 0);
        calib_done = 1'b1;
        wait_done(400, "t3_write_done");
        check("t3_write_first", exp_cmd.size(), 1);
        wait_done(1000, "t3_read_done");
        tick();
        check("t3_wr_count", n_wr_en - s_wr, 64);
        check("t3_idle", busy, 1'b0);
        check("t3_overrun_sticky", overrun, 1'b1);

        // write-FIFO and command-FIFO backpressure
        load_wr_block('h500, 64'h5000);
        exp_cmd.push_back({3'b000, 30'h2800});
        s_wr = n_wr_en; s_cmd = n_cmd;
        wr_addr = 23'h500; wr_req = 1'b1; tick(); wr_req = 1'b0;
        k = 0;
        while (n_wr_en - s_wr < 30 && k < 200) begin tick(); k++; end
        wr_full = 1'b1;
        repeat (5) tick();
        check("t4_wr_stalled", n_wr_en - s_wr, 30);
        wr_full = 1'b0;
        cmd_full = 1'b1;
        k = 0;
        while (n_wr_en - s_wr < 64 && k < 200) begin tick(); k++; end
        repeat (20) tick();
        check("t4_cmd_stalled", n_cmd - s_cmd, 0);
        check("t4_busy_stalled", busy, 1'b1);
        cmd_full = 1'b0;
        wait_done(50, "t4_done");
        check("t4_cmd_count", n_cmd - s_cmd, 1);
        check("t4_wr_drained", exp_wr.size(), 0);

        // reset in the middle of a read, with a write pending
        rd_base = 64'h7000;
        expect_rd_block('h400, 64'h7000, 64);
        exp_cmd.push_back({3'b001, 30'h2000});
        s_bw = n_bufw;
        rd_addr = 23'h400; rd_req = 1'b1; tick(); rd_req = 1'b0;
        k = 0;
        while (n_bufw - s_bw < 10 && k < 200) begin tick(); k++; end
        wr_addr = 23'h600; wr_req = 1'b1; tick(); wr_req = 1'b0;
        check("t5_busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        tick();
        check_reset_outs("t5_reset");
        exp_bufw.delete();
        rfifo.delete();
        reset = 1'b0;
        s_st = n_strobe;
        repeat (10) tick();
        check("t5_pend_cleared", busy, 1'b0);
        check("t5_no_strobes", n_strobe - s_st, 0);

`ifdef MCB_SCHED_TIMEOUT_EN
        // read watchdog: three words then a permanently empty FIFO
        rd_supply = 3; rd_base = 64'h9000;
        expect_rd_block('h700, 64'h9000, 3);
        exp_cmd.push_back({3'b001, 30'h3800});
        s_rd = n_rd_en; s_bw = n_bufw;
        rd_addr = 23'h700; rd_req = 1'b1; tick(); rd_req = 1'b0;
        wait_done(1200, "t6_done");
        check("t6_timeout", timeout, 1'b1);
        check("t6_bufw_count", n_bufw - s_bw, 3);
        check("t6_rd_count", n_rd_en - s_rd, 3);
        rd_supply = 64;
`else
        check("t6_timeout_tied", timeout, 1'b0);
`endif

        tick();
        check("end_wr_queue", exp_wr.size(), 0);
        check("end_cmd_queue", exp_cmd.size(), 0);
        check("end_bufw_queue", exp_bufw.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
